// File: rtl/pmem_arbiter_rr_pkg.sv
// rtl/pmem_arbiter_rr_pkg.sv - shared types for the physical-memory arbiter
package lc3b_types;

  typedef logic [127:0] lc3b_c_block;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pmem_arbiter_rr_if.sv
// rtl/pmem_arbiter_rr_if.sv - cache-channel and physical-memory bus bundle
interface pmem_arbiter_rr_if #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int BLOCK_W = 128
);

  logic [NUM_CH-1:0]         ch_read;
  logic [NUM_CH-1:0]         ch_write;
  logic [NUM_CH*ADDR_W-1:0]  ch_address;
  logic [NUM_CH*BLOCK_W-1:0] ch_wdata;
  logic [BLOCK_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]         ch_resp;
  logic                      pmem_read;
  logic                      pmem_write;
  logic [ADDR_W-1:0]         pmem_address;
  logic [BLOCK_W-1:0]        pmem_wdata;
  logic                      pmem_resp;
  logic [BLOCK_W-1:0]        pmem_rdata;
  logic                      busy;

  modport slave (
    input  ch_read, ch_write, ch_address, ch_wdata, pmem_resp, pmem_rdata,
    output ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, busy
  );

  modport master (
    output ch_read, ch_write, ch_address, ch_wdata, pmem_resp, pmem_rdata,
    input  ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, busy
  );

endinterface

// File: rtl/pmem_arbiter_rr_picker.sv
// rtl/pmem_arbiter_rr_picker.sv - combinational winner select, rotating or fixed priority
module rr_priority_picker #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              rr_mode,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Fixed mode is the rotating search with the pointer pinned at channel 0.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = rr_mode ? IDX_W'((int'(ptr) + k) % NUM_CH) : IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/pmem_arbiter_rr.sv
// rtl/pmem_arbiter_rr.sv - arbitrates cache channels onto one physical-memory port
module pmem_arbiter_rr
  import lc3b_types::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int BLOCK_W = $bits(lc3b_c_block),
  parameter int RR_MODE = 1
) (
  input  logic clk,
  input  logic rst_n,
  pmem_arbiter_rr_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t         state;
  arb_state_t         next_state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               lat_read;
  logic               lat_write;
  logic [ADDR_W-1:0]  lat_address;
  logic [BLOCK_W-1:0] lat_wdata;
  logic [NUM_CH-1:0]  req;

  assign req = bus.ch_read | bus.ch_write;

  rr_priority_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
    .req     (req),
    .ptr     (rr_ptr),
    .rr_mode (RR_MODE != 0),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_valid) next_state = ACCESS;
      ACCESS:  if (bus.pmem_resp) next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A channel raising read and write together is served as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant       <= '0;
      lat_read    <= 1'b0;
      lat_write   <= 1'b0;
      lat_address <= '0;
      lat_wdata   <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant       <= pick_idx;
        lat_write   <= bus.ch_write[pick_idx];
        lat_read    <= ~bus.ch_write[pick_idx];
        lat_address <= bus.ch_address[pick_idx*ADDR_W +: ADDR_W];
        lat_wdata   <= bus.ch_wdata[pick_idx*BLOCK_W +: BLOCK_W];
      end
      if (state == ACCESS && bus.pmem_resp)
        rr_ptr <= (grant == IDX_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    bus.pmem_read    = (state == ACCESS) && lat_read;
    bus.pmem_write   = (state == ACCESS) && lat_write;
    bus.pmem_address = lat_address;
    bus.pmem_wdata   = lat_wdata;
    bus.busy         = (state != IDLE);
    bus.ch_resp      = '0;
    if (state == ACCESS && bus.pmem_resp)
      bus.ch_resp = NUM_CH'(1) << grant;
  end

  assign bus.ch_rdata = bus.pmem_rdata;

endmodule
